// File: rtl/lsu_access_controller.sv
// Load/store sequencer between execute and a byte-enabled data memory: lane steering,
// load extension, and two-cycle splitting of word-crossing accesses.
module lsu_access_controller #(
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        resp_split,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_read_byte_en,
  output logic [3:0]  mem_write_byte_en,
  input  logic [31:0] mem_data_out
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_SECOND = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Handshake: a request transfers on a clk edge with req_valid && req_ready; a response
  // transfers on a clk edge with resp_valid && resp_ready, and is held stable until then.
  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [55:0] buf_q, buf_d;
  logic        error_q, error_d;
  logic        split_q, split_d;

  logic [2:0]  req_size;
  logic        req_bad_f3, req_cross, req_illegal;
  logic [7:0]  lane_mask, lanes8;
  logic [31:0] wide_hi, raw, ext;

  always_comb begin
    case (req_funct3[1:0])
      2'd0:    req_size = 3'd1;
      2'd1:    req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    if (req_write) req_bad_f3 = (req_funct3 > 3'd2);
    else           req_bad_f3 = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    req_cross   = ({1'b0, req_address[1:0]} + req_size) > 3'd4;
    req_illegal = req_bad_f3 || (req_cross && (ALLOW_MISALIGNED == 0));
  end

  // Lane steering for the latched request; bytes past lane 3 spill into the second cycle.
  always_comb begin
    case (funct3_q[1:0])
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      default: lane_mask = 8'h0F;
    endcase
    lanes8 = lane_mask << addr_q[1:0];
    case (addr_q[1:0])
      2'd1:    wide_hi = wdata_q >> 24;
      2'd2:    wide_hi = wdata_q >> 16;
      2'd3:    wide_hi = wdata_q >> 8;
      default: wide_hi = 32'h0;
    endcase
  end

  always_comb begin
    mem_address       = 32'h0;
    mem_data_in       = 32'h0;
    mem_read_byte_en  = 4'h0;
    mem_write_byte_en = 4'h0;
    if (state_q == S_FIRST) begin
      mem_address = {addr_q[31:2], 2'b00};
      mem_data_in = wdata_q << {addr_q[1:0], 3'b000};
      if (write_q) mem_write_byte_en = lanes8[3:0];
      else         mem_read_byte_en  = lanes8[3:0];
    end else if (state_q == S_SECOND) begin
      mem_address = {addr_q[31:2], 2'b00} + 32'd4;
      mem_data_in = wide_hi;
      if (write_q) mem_write_byte_en = lanes8[7:4];
      else         mem_read_byte_en  = lanes8[7:4];
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    error_d  = error_q;
    split_d  = split_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_address;
          wdata_d  = req_wdata;
          buf_d    = 56'h0;
          error_d  = req_illegal;
          split_d  = 1'b0;
          state_d  = req_illegal ? S_RESP : S_FIRST;
        end
      end
      S_FIRST: begin
        buf_d[31:0] = mem_data_out;
        if (|lanes8[7:4]) begin
          split_d = 1'b1;
          state_d = S_SECOND;
        end else begin
          state_d = S_RESP;
        end
      end
      S_SECOND: begin
        // Only the low three bytes of the second word can ever reach the result.
        buf_d[55:32] = mem_data_out[23:0];
        state_d      = S_RESP;
      end
      default: begin
        if (resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      buf_q    <= 56'h0;
      error_q  <= 1'b0;
      split_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      error_q  <= error_d;
      split_q  <= split_d;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    raw = buf_q[31:0];
      2'd1:    raw = buf_q[39:8];
      2'd2:    raw = buf_q[47:16];
      default: raw = buf_q[55:24];
    endcase
    case (funct3_q)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd2:    ext = raw;
      3'd4:    ext = {24'h0, raw[7:0]};
      3'd5:    ext = {16'h0, raw[15:0]};
      default: ext = 32'h0;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && reset;
  assign resp_valid = (state_q == S_RESP);
  assign resp_error = resp_valid && error_q;
  assign resp_split = resp_valid && split_q;
  assign resp_rdata = (resp_valid && !write_q && !error_q) ? ext : 32'h0;
endmodule

// File: tb/tb_lsu_access_controller.sv
// Directed bench for lsu_access_controller: a vector table on a misaligned-capable instance,
// plus hand sequences for the reject-only instance and reset in the middle of a split store.
module tb_lsu_access_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_ready, resp_error, resp_split;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic [3:0]  mem_read_byte_en, mem_write_byte_en;

  logic        req_valid_0, req_ready_0, req_write_0;
  logic [2:0]  req_funct3_0;
  logic [31:0] req_address_0, req_wdata_0;
  logic        resp_valid_0, resp_ready_0, resp_error_0, resp_split_0;
  logic [31:0] resp_rdata_0, mem_address_0, mem_data_in_0, mem_data_out_0;
  logic [3:0]  mem_read_byte_en_0, mem_write_byte_en_0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_access_controller #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .resp_split(resp_split),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_byte_en(mem_read_byte_en), .mem_write_byte_en(mem_write_byte_en),
    .mem_data_out(mem_data_out)
  );

  lsu_access_controller #(.ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_0), .req_ready(req_ready_0), .req_write(req_write_0),
    .req_funct3(req_funct3_0), .req_address(req_address_0), .req_wdata(req_wdata_0),
    .resp_valid(resp_valid_0), .resp_ready(resp_ready_0), .resp_rdata(resp_rdata_0),
    .resp_error(resp_error_0), .resp_split(resp_split_0),
    .mem_address(mem_address_0), .mem_data_in(mem_data_in_0),
    .mem_read_byte_en(mem_read_byte_en_0), .mem_write_byte_en(mem_write_byte_en_0),
    .mem_data_out(mem_data_out_0)
  );

  // Word memory model, 1 KB aliased; preloaded on the first edges while reset is held.
  logic [31:0] mem [0:255];
  logic        mem_load;
  assign mem_data_out = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h3F] <= 32'h11111111;
      mem[8'h40] <= 32'h44332211;
      mem[8'h41] <= 32'h88776655;
      mem[8'h00] <= 32'h01020304;
      mem[8'hFF] <= 32'hCAFEF00D;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_write_byte_en[b]) mem[mem_address[9:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
    end
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, a1;
    logic [3:0]  e1;
    logic [31:0] d1, a2;
    logic [3:0]  e2;
    logic [31:0] d2, rdata;
    logic        err, split;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic wr, logic [2:0] f3, logic [31:0] addr, wdata,
                              a1, logic [3:0] e1, logic [31:0] d1, a2, logic [3:0] e2,
                              logic [31:0] d2, rdata, logic err, split, int lat);
    vec_t v;
    v.name = name; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.a1 = a1; v.e1 = e1; v.d1 = d1; v.a2 = a2; v.e2 = e2; v.d2 = d2;
    v.rdata = rdata; v.err = err; v.split = split; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    check({v.name, " req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3;
    req_address = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.err) begin
      check({v.name, " en"}, {24'b0, mem_read_byte_en, mem_write_byte_en}, 32'h0);
      check({v.name, " addr"}, mem_address, 32'h0);
    end else begin
      check({v.name, " addr1"}, mem_address, v.a1);
      check({v.name, " en1"}, {24'b0, mem_read_byte_en, mem_write_byte_en},
            v.wr ? {28'b0, v.e1} : {24'b0, v.e1, 4'b0});
      check({v.name, " data1"}, mem_data_in, v.d1);
    end
    cyc = 1;
    if (v.split) begin
      @(posedge clk); #1;
      cyc = 2;
      check({v.name, " addr2"}, mem_address, v.a2);
      check({v.name, " en2"}, {24'b0, mem_read_byte_en, mem_write_byte_en},
            v.wr ? {28'b0, v.e2} : {24'b0, v.e2, 4'b0});
      check({v.name, " data2"}, mem_data_in, v.d2);
    end
    while (!resp_valid && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, " latency"}, cyc, v.lat);
    check({v.name, " rdata"}, resp_rdata, v.rdata);
    check({v.name, " error"}, {31'b0, resp_error}, {31'b0, v.err});
    check({v.name, " split"}, {31'b0, resp_split}, {31'b0, v.split});
    check({v.name, " req_ready_busy"}, {31'b0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_load = 1'b1;
    req_valid = 0; req_write = 0; req_funct3 = 0; req_address = 0; req_wdata = 0; resp_ready = 0;
    req_valid_0 = 0; req_write_0 = 0; req_funct3_0 = 0; req_address_0 = 0; req_wdata_0 = 0;
    resp_ready_0 = 0; mem_data_out_0 = 32'h12345678;

    vecs.push_back(mk("lw_aligned", 0, 2, 32'h100, 0, 32'h100, 4'hF, 0, 0, 0, 0, 32'h44332211, 0, 0, 2));
    vecs.push_back(mk("lb_neg",     0, 0, 32'h107, 0, 32'h104, 4'h8, 0, 0, 0, 0, 32'hFFFFFF88, 0, 0, 2));
    vecs.push_back(mk("lbu",        0, 4, 32'h107, 0, 32'h104, 4'h8, 0, 0, 0, 0, 32'h00000088, 0, 0, 2));
    vecs.push_back(mk("lh_pos",     0, 1, 32'h102, 0, 32'h100, 4'hC, 0, 0, 0, 0, 32'h00004433, 0, 0, 2));
    vecs.push_back(mk("lhu",        0, 5, 32'h106, 0, 32'h104, 4'hC, 0, 0, 0, 0, 32'h00008877, 0, 0, 2));
    vecs.push_back(mk("lh_neg",     0, 1, 32'h106, 0, 32'h104, 4'hC, 0, 0, 0, 0, 32'hFFFF8877, 0, 0, 2));
    vecs.push_back(mk("lw_split",   0, 2, 32'h102, 0, 32'h100, 4'hC, 0, 32'h104, 4'h3, 0, 32'h66554433, 0, 1, 3));
    vecs.push_back(mk("sh_split",   1, 1, 32'h103, 32'h0000BEEF, 32'h100, 4'h8, 32'hEF000000,
                      32'h104, 4'h1, 32'h000000BE, 0, 0, 1, 3));
    vecs.push_back(mk("lw_100_sh",  0, 2, 32'h100, 0, 32'h100, 4'hF, 0, 0, 0, 0, 32'hEF332211, 0, 0, 2));
    vecs.push_back(mk("lw_104_sh",  0, 2, 32'h104, 0, 32'h104, 4'hF, 0, 0, 0, 0, 32'h887766BE, 0, 0, 2));
    vecs.push_back(mk("lh_split",   0, 1, 32'h103, 0, 32'h100, 4'h8, 0, 32'h104, 4'h1, 0, 32'hFFFFBEEF, 0, 1, 3));
    vecs.push_back(mk("sb",         1, 0, 32'h101, 32'h000000A5, 32'h100, 4'h2, 32'h0000A500, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk("lw_100_sb",  0, 2, 32'h100, 0, 32'h100, 4'hF, 0, 0, 0, 0, 32'hEF33A511, 0, 0, 2));
    vecs.push_back(mk("lw_wrap",    0, 2, 32'hFFFFFFFE, 0, 32'hFFFFFFFC, 4'hC, 0, 32'h0, 4'h3, 0,
                      32'h0304CAFE, 0, 1, 3));
    vecs.push_back(mk("ld_f3_3",    0, 3, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("st_f3_4",    1, 4, 32'h100, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("ld_f3_6",    0, 6, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk("sw_aligned", 1, 2, 32'h104, 32'h0BADF00D, 32'h104, 4'hF, 32'h0BADF00D, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk("lw_104_sw",  0, 2, 32'h104, 0, 32'h104, 4'hF, 0, 0, 0, 0, 32'h0BADF00D, 0, 0, 2));

    // Reset state while held, then after release.
    #2;
    check("rst req_ready_held", {31'b0, req_ready}, 32'd0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst mem_outs", mem_address | mem_data_in | {24'b0, mem_read_byte_en, mem_write_byte_en}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    reset = 1'b1;
    #1;
    check("rst req_ready_released", {31'b0, req_ready}, 32'd1);
    check("rst resp_rdata", resp_rdata, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reject-only instance: misaligned LW errors out and the response is held under backpressure.
    @(negedge clk);
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_funct3_0 = 3'd2; req_address_0 = 32'h102;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    check("mis0 resp_valid", {31'b0, resp_valid_0}, 32'd1);
    check("mis0 error", {31'b0, resp_error_0}, 32'd1);
    check("mis0 rdata", resp_rdata_0, 32'h0);
    check("mis0 split", {31'b0, resp_split_0}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("mis0 hold resp_valid", {31'b0, resp_valid_0}, 32'd1);
      check("mis0 hold req_ready", {31'b0, req_ready_0}, 32'd0);
      check("mis0 hold en", {24'b0, mem_read_byte_en_0, mem_write_byte_en_0}, 32'h0);
      check("mis0 hold error", {31'b0, resp_error_0}, 32'd1);
    end
    resp_ready_0 = 1'b1;
    @(posedge clk); #1;
    resp_ready_0 = 1'b0;
    check("mis0 released resp_valid", {31'b0, resp_valid_0}, 32'd0);
    check("mis0 released req_ready", {31'b0, req_ready_0}, 32'd1);
    @(negedge clk);
    req_valid_0 = 1'b1; req_address_0 = 32'h100;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    check("al0 rd_en", {28'b0, mem_read_byte_en_0}, 32'hF);
    check("al0 addr", mem_address_0, 32'h100);
    @(posedge clk); #1;
    check("al0 resp_valid", {31'b0, resp_valid_0}, 32'd1);
    check("al0 rdata", resp_rdata_0, 32'h12345678);
    check("al0 error", {31'b0, resp_error_0}, 32'd0);
    resp_ready_0 = 1'b1;
    @(posedge clk); #1;
    resp_ready_0 = 1'b0;

    // Reset during the second half of a split store: only the first half lands.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_address = 32'h0FE; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rsw addr1", mem_address, 32'h0FC);
    check("rsw wr_en1", {28'b0, mem_write_byte_en}, 32'hC);
    check("rsw data1", mem_data_in, 32'hCCDD0000);
    @(posedge clk); #1;
    check("rsw addr2", mem_address, 32'h100);
    check("rsw wr_en2", {28'b0, mem_write_byte_en}, 32'h3);
    check("rsw data2", mem_data_in, 32'h0000AABB);
    #2;
    reset = 1'b0;
    #1;
    check("rsw mem_address", mem_address, 32'h0);
    check("rsw mem_data_in", mem_data_in, 32'h0);
    check("rsw en", {24'b0, mem_read_byte_en, mem_write_byte_en}, 32'h0);
    check("rsw resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rsw req_ready", {31'b0, req_ready}, 32'd1);
    run_vec(mk("lw_0fc_rst", 0, 2, 32'h0FC, 0, 32'h0FC, 4'hF, 0, 0, 0, 0, 32'hCCDD1111, 0, 0, 2));
    run_vec(mk("lw_100_rst", 0, 2, 32'h100, 0, 32'h100, 4'hF, 0, 0, 0, 0, 32'hEF33A511, 0, 0, 2));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
